// File: rtl/div6x3_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, start/done handshake.
// Define DIV_SELFCHECK_EN to add a q*d+r == n consistency check driving the sticky err flag.
module div6x3_seq #(
  parameter int WIDTH_N = 6,
  parameter int WIDTH_D = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_N-1:0] n,
  input  logic [WIDTH_D-1:0] d,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] q,
  output logic [WIDTH_D-1:0] r,
  output logic               div0,
  output logic               err
);

  localparam int CNT_W = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH_N-1:0] nsh_q, nsh_d;
  logic [WIDTH_D-1:0] dv_q, dv_d;
  logic [WIDTH_D-1:0] rem_q, rem_d;
  logic [WIDTH_N-1:0] q_q, q_d;
  logic [WIDTH_D-1:0] r_q, r_d;
  logic               div0_q, div0_d;

  // The dividend shifts out of the top of nsh while quotient bits shift in at
  // the bottom, so after the last step nsh holds the whole quotient.
  logic [WIDTH_D:0]   rem_sh;
  logic               q_bit;
  logic [WIDTH_D-1:0] rem_nxt;
  logic [WIDTH_N-1:0] quo_nxt;

  always_comb begin
    rem_sh  = {rem_q, nsh_q[WIDTH_N-1]};
    q_bit   = (rem_sh >= {1'b0, dv_q});
    rem_nxt = q_bit ? WIDTH_D'(rem_sh - {1'b0, dv_q}) : rem_sh[WIDTH_D-1:0];
    quo_nxt = {nsh_q[WIDTH_N-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nsh_d   = nsh_q;
    dv_d    = dv_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          nsh_d = n;
          dv_d  = d;
          cnt_d = CNT_W'(WIDTH_N - 1);
          rem_d = '0;
          // A zero divisor skips the iterations and reports immediately.
          if (d == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = '0;
            div0_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        nsh_d = quo_nxt;
        rem_d = rem_nxt;
        if (cnt_q == '0) begin
          state_d = DONE;
          q_d     = quo_nxt;
          r_d     = rem_nxt;
          div0_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nsh_q   <= '0;
      dv_q    <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nsh_q   <= nsh_d;
      dv_q    <= dv_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign q    = q_q;
  assign r    = r_q;
  assign div0 = div0_q;

`ifdef DIV_SELFCHECK_EN
  localparam int PW = WIDTH_N + WIDTH_D;

  logic [WIDTH_N-1:0] n_orig_q, n_orig_d;
  logic [PW-1:0]      chk_sum;
  logic               mismatch;
  logic               err_q, err_d;

  // The original dividend is kept because nsh is consumed by the iterations.
  always_comb begin
    n_orig_d = n_orig_q;
    if (start && (state_q != RUN)) begin
      n_orig_d = n;
    end
    chk_sum  = PW'(quo_nxt) * PW'(dv_q) + PW'(rem_nxt);
    mismatch = (chk_sum != PW'(n_orig_q)) || (rem_nxt >= dv_q);
    err_d    = err_q;
    if ((state_q == RUN) && (cnt_q == '0) && mismatch) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_orig_q <= '0;
      err_q    <= 1'b0;
    end else begin
      n_orig_q <= n_orig_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_div6x3_seq.sv
// Testbench for div6x3_seq: directed scenarios, random operations and an exhaustive
// sweep, all checked against plain n/d and n%d arithmetic.
module tb_div6x3_seq;

  localparam int WN = 6;
  localparam int WD = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [WN-1:0] n;
  logic [WD-1:0] d;
  logic          busy;
  logic          done;
  logic [WN-1:0] q;
  logic [WD-1:0] r;
  logic          div0;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [WN-1:0] expQ;
  logic [WD-1:0] expR;
  logic          expDiv0;

  div6x3_seq #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .n    (n),
    .d    (d),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r),
    .div0 (div0),
    .err  (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle; returns observing cycle 1 after acceptance.
  task automatic applyStimulus(input logic [WN-1:0] nv, input logic [WD-1:0] dv);
    n     = nv;
    d     = dv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int fromCycle, output int doneCycle);
    int c;
    c = fromCycle;
    while (done !== 1'b1 && c < 30) begin
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_qhold"}, 32'(q), 32'(expQ));
      checkOutput({tag, "_rhold"}, 32'(r), 32'(expR));
      tick();
      c++;
    end
    doneCycle = c;
  endtask

  task automatic checkResult(input string tag, input logic [WN-1:0] nv, input logic [WD-1:0] dv,
                             input int doneCycle);
    int qm;
    int rm;
    if (dv == 0) begin
      qm = (1 << WN) - 1;
      rm = 0;
    end else begin
      qm = int'(nv) / int'(dv);
      rm = int'(nv) % int'(dv);
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_latency"}, 32'(doneCycle), (dv == 0) ? 32'd1 : 32'(WN + 1));
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_q"}, 32'(q), 32'(qm));
    checkOutput({tag, "_r"}, 32'(r), 32'(rm));
    checkOutput({tag, "_div0"}, 32'(div0), (dv == 0) ? 32'd1 : 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    if (dv != 0) begin
      checkOutput({tag, "_identity"}, 32'(int'(q) * int'(dv) + int'(r)), 32'(nv));
      checkOutput({tag, "_r_lt_d"}, 32'(r < dv), 32'd1);
    end
    expQ    = WN'(qm);
    expR    = WD'(rm);
    expDiv0 = (dv == 0);
  endtask

  task automatic runOp(input string tag, input logic [WN-1:0] nv, input logic [WD-1:0] dv);
    int dc;
    applyStimulus(nv, dv);
    waitDone(tag, 1, dc);
    checkResult(tag, nv, dv, dc);
  endtask

  task automatic idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      checkOutput({tag, "_idle_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_idle_q"}, 32'(q), 32'(expQ));
      checkOutput({tag, "_idle_div0"}, 32'(div0), 32'(expDiv0));
    end
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_q"}, 32'(q), 32'd0);
    checkOutput({tag, "_r"}, 32'(r), 32'd0);
    checkOutput({tag, "_div0"}, 32'(div0), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int dc;
    logic [WN-1:0] rn;
    logic [WD-1:0] rd;

    // Reset held while a request is presented; reset must win.
    rst   = 1'b1;
    start = 1'b1;
    n     = 6'd45;
    d     = 3'd6;
    tick();
    tick();
    checkZero("reset");
    start   = 1'b0;
    rst     = 1'b0;
    expQ    = '0;
    expR    = '0;
    expDiv0 = 1'b0;
    idle("post_reset", 1);

    $display("[TB] basic division 45/6");
    runOp("t1", 6'd45, 3'd6);
    idle("t1", 1);

    $display("[TB] back-to-back with start in the done cycle");
    runOp("t2a", 6'd63, 3'd1);
    runOp("t2b", 6'd5, 3'd7);
    idle("t2", 2);

    $display("[TB] divide by zero then normal");
    runOp("t3a", 6'd20, 3'd0);
    runOp("t3b", 6'd20, 3'd4);
    idle("t3", 1);

    $display("[TB] start while busy is ignored");
    applyStimulus(6'd45, 3'd6);
    checkOutput("t4_busy1", 32'(busy), 32'd1);
    tick();
    checkOutput("t4_busy2", 32'(busy), 32'd1);
    tick();
    checkOutput("t4_busy3", 32'(busy), 32'd1);
    n     = 6'd9;
    d     = 3'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone("t4", 4, dc);
    checkResult("t4", 6'd45, 3'd6, dc);
    idle("t4", 1);

    $display("[TB] reset in the middle of an operation");
    applyStimulus(6'd45, 3'd6);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkZero("t5_after_rst");
    expQ    = '0;
    expR    = '0;
    expDiv0 = 1'b0;
    idle("t5", 8);
    runOp("t5b", 6'd45, 3'd6);
    idle("t5b", 1);

    $display("[TB] random operations");
    for (int i = 0; i < 60; i++) begin
      rn = WN'($urandom);
      rd = WD'($urandom);
      runOp("rand", rn, rd);
      idle("rand", int'($urandom_range(0, 2)));
    end

    $display("[TB] exhaustive sweep");
    for (int nv = 0; nv < (1 << WN); nv++) begin
      for (int dv = 0; dv < (1 << WD); dv++) begin
        runOp("exh", WN'(nv), WD'(dv));
      end
    end
    idle("exh", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
